// File: rtl/mem_access_unit_pkg.sv
// Shared CPU definitions for the load/store unit: size codes, FSM states,
// default ack timeout and byte-lane helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    DONE = 2'b11
  } mau_state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 255;

  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_lanes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // An access spills into the next word when offset plus length passes 4 bytes.
  function automatic logic is_split(input logic [1:0] size, input logic [1:0] offset);
    return ({2'b00, offset} + 4'(size_nbytes(size))) > 4'd4;
  endfunction

  function automatic logic [3:0] lanes_first(input logic [1:0] size, input logic [1:0] offset);
    return size_lanes(size) << offset;
  endfunction

  function automatic logic [3:0] lanes_second(input logic [1:0] size, input logic [1:0] offset);
    return 4'(({4'b0000, size_lanes(size)} << offset) >> 4);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign- or zero-extends the low 1, 2 or 4 gathered load bytes to 32 bits.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] result
);

  // se=0 replicates the top loaded bit, se=1 fills with zeros.
  always_comb begin
    result = raw;
    case (size)
      SIZE_BYTE: result = {{24{~se & raw[7]}}, raw[7:0]};
      SIZE_HALF: result = {{16{~se & raw[15]}}, raw[15:0]};
      default:   result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: splits unaligned byte/half/word accesses into one or two
// word-aligned memory transactions with a per-access ack timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  Size_s,
  input  logic        SE_s,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] MDR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  mau_state_e     state;
  logic           we_q;
  logic           se_q;
  logic [1:0]     size_q;
  logic [1:0]     off_q;
  logic [29:0]    word_q;
  logic [31:0]    wdata_q;
  logic [31:0]    load_buf;
  logic [CW-1:0]  wait_cnt;

  logic [4:0]     shift_amt;
  logic [5:0]     shift_back;
  logic           ack_seen;
  logic           timed_out;
  logic [31:0]    gathered;
  logic [31:0]    ext_result;

  assign busy       = (state != IDLE);
  assign shift_amt  = {off_q, 3'b000};
  assign shift_back = 6'd32 - {1'b0, shift_amt};
  assign ack_seen   = mem_req & mem_ack;
  assign timed_out  = (wait_cnt == CW'(ACK_TIMEOUT - 1));

  // First word supplies bytes from the offset upward; the second word fills
  // the remaining high bytes on top of what was kept from the first.
  always_comb begin
    gathered = mem_rdata >> shift_amt;
    if (state == ACC2)
      gathered = load_buf | (mem_rdata << shift_back);
  end

  load_extend u_load_extend (
    .raw    (gathered),
    .size   (size_q),
    .se     (se_q),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      se_q      <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      word_q    <= '0;
      wdata_q   <= '0;
      load_buf  <= '0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      MDR       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (req) begin
            we_q    <= we;
            se_q    <= SE_s;
            size_q  <= Size_s;
            off_q   <= addr[1:0];
            word_q  <= addr[31:2];
            wdata_q <= wdata;
            if (Size_s == SIZE_BAD) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ACC1;
              wait_cnt  <= '0;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= lanes_first(Size_s, addr[1:0]);
              mem_wdata <= we ? (wdata << {addr[1:0], 3'b000}) : '0;
            end
          end
        end

        ACC1, ACC2: begin
          if (ack_seen && state == ACC1 && is_split(size_q, off_q)) begin
            state     <= ACC2;
            wait_cnt  <= '0;
            load_buf  <= gathered;
            mem_addr  <= {word_q + 30'd1, 2'b00};
            mem_be    <= lanes_second(size_q, off_q);
            mem_wdata <= we_q ? (wdata_q >> shift_back) : '0;
          end else if (ack_seen || timed_out) begin
            // Completion or abort: release the bus and report through done/err.
            state     <= DONE;
            done      <= 1'b1;
            err       <= ~ack_seen;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (ack_seen && !we_q)
              MDR <= ext_result;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          err   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte-level memory
// reference model and a responder that checks every memory transaction.
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_;
  logic        req, we, SE_s;
  logic [31:0] addr, wdata;
  logic [1:0]  Size_s;
  logic        busy, done, err;
  logic [31:0] MDR;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_(rst_), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .Size_s(Size_s), .SE_s(SE_s), .busy(busy), .done(done), .err(err), .MDR(MDR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] data; } txn_t;
  typedef struct { logic err; logic [31:0] mdr; } resp_t;

  logic [7:0]  ref_mem [64];
  logic [31:0] phys_mem [16];
  txn_t        txn_q[$];
  resp_t       resp_q[$];
  logic [31:0] model_mdr;

  int checks_total = 0;
  int checks_passed = 0;
  int done_count = 0;
  int stall_mode = 0;
  int served_this_op = 0;
  bit fast = 0;

  task automatic finishRun();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic setWord(input logic [31:0] a, input logic [31:0] v);
    int w;
    w = int'((a - BASE) >> 2);
    phys_mem[w] = v;
    for (int l = 0; l < 4; l++) ref_mem[w*4 + l] = v[8*l +: 8];
  endtask

  // Reference: the access covers bytes a..a+n-1; each word touched is one
  // transaction. Only the first words_served words get acknowledged.
  task automatic modelOp(input logic op_we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] size, input logic se, input int words_served);
    int n, ai, first_w, last_w;
    resp_t r;
    txn_t t;
    logic [31:0] val;
    if (size == 2'b11) begin
      r.err = 1'b1; r.mdr = model_mdr; resp_q.push_back(r);
      return;
    end
    n = 1 << size;
    ai = int'(a);
    first_w = ai >> 2;
    last_w = (ai + n - 1) >> 2;
    for (int w = first_w; w <= last_w; w++) begin
      if (w - first_w >= words_served) break;
      t.we = op_we; t.addr = 32'(w * 4); t.be = 4'b0000; t.data = '0;
      for (int l = 0; l < 4; l++) begin
        int b;
        b = w * 4 + l;
        if (b >= ai && b < ai + n) begin
          t.be[l] = 1'b1;
          t.data[8*l +: 8] = wd[8*(b - ai) +: 8];
          if (op_we) ref_mem[b - int'(BASE)] = wd[8*(b - ai) +: 8];
        end
      end
      txn_q.push_back(t);
    end
    if (last_w - first_w + 1 > words_served) begin
      r.err = 1'b1; r.mdr = model_mdr;
    end else if (!op_we) begin
      val = '0;
      for (int k = 0; k < n; k++) val[8*k +: 8] = ref_mem[ai + k - int'(BASE)];
      if (!se) for (int bt = 8*n; bt < 32; bt++) val[bt] = val[8*n - 1];
      model_mdr = val;
      r.err = 1'b0; r.mdr = val;
    end else begin
      r.err = 1'b0; r.mdr = model_mdr;
    end
    resp_q.push_back(r);
  endtask

  // Memory responder: random ack delay, stray acks while idle, optional stalls.
  initial begin : responder
    int delay_left;
    bit active;
    bit blocked;
    int idx;
    txn_t e;
    mem_ack = 1'b0; mem_rdata = '0; delay_left = 0; active = 0;
    forever begin
      @(negedge clk);
      if (!rst_) begin mem_ack = 1'b0; active = 0; continue; end
      if (mem_req) begin
        if (!active) begin
          active = 1;
          delay_left = fast ? 0 : int'($urandom_range(0, 3));
        end
        blocked = (stall_mode == 1) || (stall_mode == 2 && served_this_op >= 1);
        if (!blocked && delay_left == 0) begin
          served_this_op++;
          if (txn_q.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL unexpected_txn: got access at 0x%08h, expected none", mem_addr);
          end else begin
            e = txn_q.pop_front();
            checkOutput("mem_addr", mem_addr, e.addr);
            checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            if (e.we) begin
              checkOutput("mem_be", {28'd0, mem_be}, {28'd0, e.be});
              checkOutput("mem_wdata", mem_wdata & {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}}, e.data);
            end
          end
          idx = int'((mem_addr - BASE) >> 2);
          if (mem_addr >= BASE && idx < 16) begin
            if (mem_we)
              for (int l = 0; l < 4; l++)
                if (mem_be[l]) phys_mem[idx][8*l +: 8] = mem_wdata[8*l +: 8];
            mem_rdata = mem_we ? $urandom : phys_mem[idx];
          end else begin
            mem_rdata = $urandom;
          end
          mem_ack = 1'b1;
          active = 0;
        end else begin
          mem_ack = 1'b0;
          if (delay_left > 0) delay_left--;
        end
      end else begin
        active = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    resp_t r;
    if (rst_ === 1'b1 && done === 1'b1) begin
      done_count++;
      if (resp_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL unexpected_done: got done with err=%0b MDR=0x%08h, expected none", err, MDR);
      end else begin
        r = resp_q.pop_front();
        checkOutput("err", {31'd0, err}, {31'd0, r.err});
        checkOutput("MDR", MDR, r.mdr);
      end
    end
  end

  task automatic applyStimulus(input logic op_we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] size, input logic se, input int mode,
                               output int cycles, output int req_cycles, output logic req_at_done);
    int start;
    stall_mode = mode;
    served_this_op = 0;
    modelOp(op_we, a, wd, size, se, (mode == 0) ? 2 : ((mode == 2) ? 1 : 0));
    @(negedge clk); #1;
    start = done_count;
    req = 1'b1; we = op_we; addr = a; wdata = wd; Size_s = size; SE_s = se;
    cycles = 0; req_cycles = 0; req_at_done = 1'b0;
    while (1) begin
      @(negedge clk); #1;
      cycles++;
      if (done_count != start) begin req_at_done = mem_req; break; end
      if (mem_req) req_cycles++;
      if (cycles > 600) begin
        checks_total++;
        $display("[TB] FAIL done_wait: no done after %0d cycles, expected one", cycles);
        finishRun();
      end
      // Junk requests while busy must be ignored.
      req = busy & 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      Size_s = 2'($urandom_range(0, 3)); SE_s = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    @(negedge clk); #1;
    stall_mode = 0;
  endtask

  initial begin : main
    int cyc, rcyc, start;
    logic rad;
    logic [1:0] sz;
    logic [31:0] a;
    req = 0; we = 0; addr = 0; wdata = 0; Size_s = 0; SE_s = 0;
    model_mdr = '0;
    for (int i = 0; i < 16; i++) setWord(BASE + 32'(i * 4), $urandom);
    rst_ = 1'b1;
    #2 rst_ = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset MDR", MDR, 32'd0);
    checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset mem_be", {28'd0, mem_be}, 32'd0);
    rst_ = 1'b1;

    $display("[TB] split word load");
    setWord(32'h1000, 32'h44332211); setWord(32'h1004, 32'h88776655);
    applyStimulus(0, 32'h1002, 0, 2'b10, 0, 0, cyc, rcyc, rad);
    checkOutput("lw split MDR", MDR, 32'h66554433);
    checkOutput("lw split reads", served_this_op, 2);

    $display("[TB] byte loads with extension");
    setWord(32'h1000, 32'h8C332211);
    applyStimulus(0, 32'h1003, 0, 2'b00, 0, 0, cyc, rcyc, rad);
    checkOutput("lb sext MDR", MDR, 32'hFFFFFF8C);
    checkOutput("lb sext reads", served_this_op, 1);
    applyStimulus(0, 32'h1003, 0, 2'b00, 1, 0, cyc, rcyc, rad);
    checkOutput("lb zext MDR", MDR, 32'h0000008C);

    $display("[TB] split half store");
    applyStimulus(1, 32'h1003, 32'h0000BEEF, 2'b01, 0, 0, cyc, rcyc, rad);
    checkOutput("sh word0", phys_mem[0], 32'hEF332211);
    checkOutput("sh word1 low byte", {24'd0, phys_mem[1][7:0]}, 32'h000000BE);

    $display("[TB] illegal size");
    applyStimulus(0, 32'h1008, 0, 2'b11, 0, 0, cyc, rcyc, rad);
    checkOutput("illegal latency", cyc, 1);
    checkOutput("illegal mem_req cycles", rcyc, 0);
    checkOutput("illegal MDR hold", MDR, 32'h0000008C);

    $display("[TB] minimum latency");
    fast = 1;
    applyStimulus(0, 32'h1004, 0, 2'b10, 0, 0, cyc, rcyc, rad);
    fast = 0;
    checkOutput("min latency", cyc, 2);

    $display("[TB] ack timeout");
    applyStimulus(0, 32'h1010, 0, 2'b10, 0, 1, cyc, rcyc, rad);
    checkOutput("timeout mem_req cycles", rcyc, 255);
    checkOutput("timeout mem_req at done", {31'd0, rad}, 32'd0);

    $display("[TB] split store with second-half timeout");
    setWord(32'h1010, 32'h00000000); setWord(32'h1014, 32'h00000000);
    applyStimulus(1, 32'h1013, 32'h0000CAFE, 2'b01, 0, 2, cyc, rcyc, rad);
    checkOutput("partial store word0", phys_mem[4], 32'hFE000000);
    checkOutput("partial store word1", phys_mem[5], 32'h00000000);

    $display("[TB] reset mid-access");
    stall_mode = 1; served_this_op = 0;
    @(negedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h1004; Size_s = 2'b10;
    @(negedge clk); #1;
    req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("busy before reset", {31'd0, busy}, 32'd1);
    start = done_count;
    rst_ = 1'b0;
    #1;
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst MDR", MDR, 32'd0);
    checkOutput("rst err", {31'd0, err}, 32'd0);
    model_mdr = '0;
    repeat (2) @(negedge clk);
    #1 rst_ = 1'b1;
    stall_mode = 0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("done after reset", done_count, start);

    $display("[TB] random accesses");
    for (int i = 0; i < 250; i++) begin
      a = BASE + 32'($urandom_range(0, 47));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0) ? 2 : 0, cyc, rcyc, rad);
    end

    checkOutput("leftover responses", resp_q.size(), 0);
    checkOutput("leftover txns", txn_q.size(), 0);
    finishRun();
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 255, giving the mem_ack wait cycles per access before abort.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 1, start a load/store; sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-006 The block SHALL have port addr, input, 32, byte address from ALU result F.
REQ-007 The block SHALL have port wdata, input, 32, store data (rs2), LSB-aligned.
REQ-008 The block SHALL have port Size_s, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 The block SHALL have port SE_s, input, 1, load extension: 0 sign-extend, 1 zero-extend.
REQ-010 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1, valid with done: illegal size or timeout.
REQ-013 The block SHALL have port MDR, output, 32, extended load result.
REQ-014 The block SHALL have memory-side ports mem_req (out 1), mem_we (out 1), mem_addr (out 32, word-aligned), mem_be (out 4), mem_wdata (out 32), mem_rdata (in 32), mem_ack (in 1).

Function
REQ-015 The FSM SHALL have states IDLE, ACC1, ACC2, DONE.
REQ-016 IDLE with req=1 SHALL latch we/addr/wdata/Size_s/SE_s and go to ACC1; with Size_s=11 it SHALL go directly to DONE with err=1 and no memory transaction.
REQ-017 With offset o=addr[1:0] and n=1/2/4 bytes, the access SHALL be split when o+n>4.
REQ-018 ACC1 SHALL drive mem_req=1, mem_addr={addr[31:2],2'b00}, and hold all memory outputs stable until mem_ack=1 is sampled.
REQ-019 ACC2 SHALL do the same at mem_addr+4; ACC1 SHALL go to ACC2 on ack if split, else to DONE.
REQ-020 Store byte k of wdata SHALL go to lane (o+k) mod 4; mem_be SHALL mark lanes o..min(3,o+n-1) in ACC1 and lanes 0..o+n-5 in ACC2.
REQ-021 Load byte k of the result SHALL be memory byte addr+k, taken from mem_rdata captured at each ack.
REQ-022 The result SHALL then be extended from n bytes per SE_s.
REQ-023 MDR SHALL update only when a load completes without error; it SHALL otherwise hold.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 Minimum latency SHALL be: req sampled at edge 0, mem_req high after edge 0, ack at edge 1, done high after edge 1.
REQ-026 A per-access wait counter SHALL reset on entering ACC1/ACC2; on reaching ACK_TIMEOUT it SHALL go to DONE with err=1, mem_req=0.
REQ-027 On a split store timeout, first-half writes SHALL remain committed.
REQ-028 req SHALL be ignored while busy=1.
REQ-029 mem_ack SHALL be ignored while mem_req=0.

Reset
REQ-030 rst_=0 SHALL force IDLE, busy=0, done=0, err=0, MDR=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and wait counter=0, immediately and mid-transaction.
REQ-031 An access interrupted by reset SHALL produce no done.

Structure
REQ-032 Size encodings, FSM state encodings and the ACK_TIMEOUT default SHALL live in the shared CPU package used by CU.
REQ-033 One sub-module, load_extend (combinational: n bytes + SE_s -> 32-bit), SHALL be instantiated.

Verification
REQ-034 mem[0x1000]=0x44332211, mem[0x1004]=0x88776655; lw 0x1002 -> two reads (0x1000, 0x1004), MDR=0x66554433, done once.
REQ-035 mem[0x1000]=0x8C332211; lb 0x1003 SE_s=0 -> MDR=0xFFFFFF8C; SE_s=1 -> MDR=0x0000008C; one read each.
REQ-036 sh 0x1003 wdata=0x0000BEEF -> write 0x1000 be=1000 data 0xEF000000, then write 0x1004 be=0001 data 0x000000BE.
REQ-037 Size_s=11 req -> done=1, err=1 next cycle; mem_req never asserted; MDR unchanged.
REQ-038 mem_ack held 0 -> after 255 wait cycles done=1, err=1, mem_req=0; rst_ pulsed mid-ACC1 -> all outputs 0 at once, no done.
